// File: rtl/wb_queue.sv
// wb_queue: in-order write-back result queue.
// Captures register write-back results (we/rwd) from the processing unit and
// releases them oldest-first over a dv/dr valid/ready handshake.
// Optional build macro WB_QUEUE_OVF_EN adds a sticky overflow flag (ovf) and a
// saturating discarded-write counter (drops); without it both outputs read 0.
// Data width is `WIDTH+1 bits; `WIDTH defaults to 15 (16-bit entries).
//
// Handshake: an entry is transferred (popped) on a rising clk edge where
// dv=1 and dr=1. dv/dout stay stable while dv=1 and dr=0. dr is ignored while
// dv=0. A push is accepted when we=1 and the queue is not full, or when it is
// full but a pop happens in the same cycle. A pushed entry reaches dv/dout only
// in the cycle after its push edge (no fall-through).

`ifndef WIDTH
`define WIDTH 15
`endif

module wb_queue #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [`WIDTH:0]          rwd,
   output logic                     dv,
   output logic [`WIDTH:0]          dout,
   input  logic                     dr,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic [7:0]               drops
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Storage and bookkeeping state
   logic [`WIDTH:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            push;
   logic            pop;

   // Status flags come from the occupancy count only; pointers alone cannot
   // tell full from empty.
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign dv    = ~empty;
   assign count = count_q;

   // Head entry is shown only while valid, so reset forces dout to 0 at once.
   assign dout  = dv ? mem_q[rd_ptr_q] : '0;

   // Transfer conditions. A full queue can still take a push when the head
   // leaves in the same cycle, which keeps streaming at one entry per cycle.
   assign pop   = dv & dr;
   assign push  = we & (~full | pop);

   // Next-state for pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointer and count registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; stale contents are harmless because count gates visibility
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= rwd;
      end
   end

`ifdef WB_QUEUE_OVF_EN
   // A write that finds the queue full with no departing head is discarded
   logic       ovf_evt;
   logic       ovf_q;
   logic [7:0] drops_q;

   assign ovf_evt = we & full & ~pop;
   assign ovf     = ovf_q;
   assign drops   = drops_q;

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q   <= 1'b0;
         drops_q <= 8'd0;
      end else if (ovf_evt) begin
         ovf_q <= 1'b1;
         if (drops_q != 8'hFF) begin
            drops_q <= drops_q + 8'd1;
         end
      end
   end
`else
   assign ovf   = 1'b0;
   assign drops = 8'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed testbench for wb_queue (DEPTH=4) with a scoreboard queue.

`ifndef WIDTH
`define WIDTH 15
`endif

module tb_wb_queue;

   localparam int DEPTH = 4;
   localparam int W     = `WIDTH + 1;

   logic         clk;
   logic         rst;
   logic         we;
   logic [W-1:0] rwd;
   logic         dv;
   logic [W-1:0] dout;
   logic         dr;
   logic         full;
   logic         empty;
   logic [2:0]   count;
   logic         ovf;
   logic [7:0]   drops;

   wb_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .rwd   (rwd),
      .dv    (dv),
      .dout  (dout),
      .dr    (dr),
      .full  (full),
      .empty (empty),
      .count (count),
      .ovf   (ovf),
      .drops (drops)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard and reference model state
   logic [W-1:0] exp_q[$];
   int           m_cnt;
   logic         m_ovf;
   int           m_drops;
   int           max_cnt;
   int           total;
   int           bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance.
   // Called at posedge+1; checks happen at posedge+2, far from any edge.
   task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
      logic pop_m, acc_m, ovf_m;
      logic [W-1:0] e;
      we  = w;
      rwd = d;
      dr  = r;
      #1;
      pop_m = (m_cnt != 0) && r;
      acc_m = w && ((m_cnt < DEPTH) || pop_m);
      ovf_m = w && (m_cnt == DEPTH) && !pop_m;
      check("dv",    dv,    (m_cnt != 0));
      check("count", count, m_cnt);
      check("full",  full,  (m_cnt == DEPTH));
      check("empty", empty, (m_cnt == 0));
      check("ovf",   ovf,   m_ovf);
      check("drops", drops, m_drops);
      if (pop_m) begin
         e = exp_q.pop_front();
         check("dout", dout, e);
      end
      if (acc_m) exp_q.push_back(d);
      if (acc_m && !pop_m) m_cnt++;
      if (pop_m && !acc_m) m_cnt--;
      if (m_cnt > max_cnt) max_cnt = m_cnt;
`ifdef WB_QUEUE_OVF_EN
      if (ovf_m) begin
         m_ovf = 1'b1;
         if (m_drops < 255) m_drops++;
      end
`else
      if (ovf_m) m_ovf = 1'b0;
`endif
      @(posedge clk);
      #1;
      we = 1'b0;
      dr = 1'b0;
   endtask

   // Pop everything the model holds (bounded by DEPTH+2 cycles)
   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) begin
         if (m_cnt != 0) cyc(1'b0, '0, 1'b1);
      end
      check("drained_empty", empty, 1'b1);
      check("drained_sb", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   initial begin
      total = 0; bad = 0; max_cnt = 0;
      m_cnt = 0; m_ovf = 1'b0; m_drops = 0;
      we = 1'b0; dr = 1'b0; rwd = '0;
      rst = 1'b1;
      #2;
      // Reset state
      check("rst_dv",    dv,    1'b0);
      check("rst_count", count, 3'd0);
      check("rst_empty", empty, 1'b1);
      check("rst_dout",  dout,  '0);
      check("rst_ovf",   ovf,   1'b0);
      check("rst_drops", drops, 8'd0);
      do_reset();

      // Single entry: dv must stay low in the push cycle, visible next cycle
      cyc(1'b1, 16'h0011, 1'b1);
      cyc(1'b0, '0, 1'b1);
      check("single_empty", count, 3'd0);

      // Ordering and backpressure
      for (int i = 1; i <= 4; i++) cyc(1'b1, W'(i), 1'b0);
      check("order_full", full, 1'b1);
      check("order_count", count, 3'd4);
      cyc(1'b0, '0, 1'b0);           // head holds under dr=0
      check("hold_dout", dout, 16'h0001);
      drain();

      // Simultaneous push/pop while full
      for (int i = 0; i < 4; i++) cyc(1'b1, W'($urandom_range(16'h0100, 16'hFFFF)), 1'b0);
      cyc(1'b1, 16'h0055, 1'b1);
      check("simul_count", count, 3'd4);
      check("simul_ovf", ovf, 1'b0);
      drain();

      // Overflow: two discarded writes, contents unchanged
      for (int i = 0; i < 4; i++) cyc(1'b1, W'(16'h0020 + i), 1'b0);
      cyc(1'b1, 16'h00AA, 1'b0);
      cyc(1'b1, 16'h00AA, 1'b0);
      check("ovf_count", count, 3'd4);
      check("ovf_head", dout, 16'h0020);
`ifdef WB_QUEUE_OVF_EN
      check("ovf_flag", ovf, 1'b1);
      check("ovf_drops", drops, 8'd2);
`else
      check("ovf_flag", ovf, 1'b0);
      check("ovf_drops", drops, 8'd0);
`endif
      drain();
      do_reset();

      // Pointer wrap: 3 in flight, 10 push/pop pairs
      max_cnt = 0;
      for (int i = 0; i < 3; i++) cyc(1'b1, W'(16'h0300 + i), 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, W'(16'h0400 + i), 1'b1);
      check("wrap_count", count, 3'd3);
      drain();
      check("wrap_max", (max_cnt <= 4), 1'b1);

      // Async reset mid-burst with count=3
      for (int i = 0; i < 3; i++) cyc(1'b1, W'(16'h0600 + i), 1'b0);
      check("pre_rst_count", count, 3'd3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_dv",    dv,    1'b0);
      check("arst_count", count, 3'd0);
      check("arst_ovf",   ovf,   1'b0);
      check("arst_dout",  dout,  '0);
      we = 1'b1; rwd = 16'h0099; dr = 1'b1;   // must be ignored under reset
      @(posedge clk);
      #1;
      check("rst_hold_count", count, 3'd0);
      we = 1'b0; dr = 1'b0;
      rst = 1'b0;
      exp_q.delete();
      m_cnt = 0; m_ovf = 1'b0; m_drops = 0;
      cyc(1'b1, 16'h0077, 1'b0);
      check("post_rst_count", count, 3'd1);
      check("post_rst_first", dout, 16'h0077);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
